// File: rtl/muldiv_multicycle_sequencer.sv
// muldiv_multicycle_sequencer
// Takes one multiply/divide op from the main controller, starts the
// long-latency arithmetic unit, waits out the class latency and then
// issues a single write-back cycle (HI/LO or GPR) with a done pulse.
// Also handles back-to-back issue from WB, abort, divide-by-zero
// short-cut and illegal op reporting.
module muldiv_multicycle_sequencer #(
  parameter int MULT_CYCLES   = 17,
  parameter int DIV_CYCLES    = 33,
  parameter bit DIV_ZERO_SKIP = 1'b1,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                  clock_in,
  input  logic                  reset_signal,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            op_code,
  input  logic [REG_ADDR_W-1:0] op_rd,
  input  logic                  divisor_zero,
  input  logic                  abort,
  output logic                  unit_start,
  output logic                  unit_div,
  output logic                  unit_signed,
  output logic                  busy,
  output logic                  hi_wena,
  output logic                  lo_wena,
  output logic                  rf_wena,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic                  done,
  output logic                  dz_flag,
  output logic                  illegal_op
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // The counter is loaded with latency-1 so that count 0 marks the last RUN cycle
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WB
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             op_is_mul;
  logic             wb_hilo;
  logic             wb_rf;
  logic             wb_done;
  logic             wb_dz;

  logic accept;
  logic op_legal;
  logic op_div;
  logic op_signed;
  logic dz_skip;

  // Handshake and decode of the op currently offered by the controller
  always_comb begin
    op_ready  = ((state == IDLE) || (state == WB)) && !abort && !reset_signal;
    accept    = op_valid && op_ready;
    op_legal  = (op_code <= 3'd4);
    op_div    = (op_code == 3'd2) || (op_code == 3'd3);
    op_signed = (op_code == 3'd0) || (op_code == 3'd2) || (op_code == 3'd4);
    dz_skip   = DIV_ZERO_SKIP && op_div && divisor_zero;
  end

  // Write-back strobes are registered but an abort arriving during WB must still kill them
  always_comb begin
    busy    = (state != IDLE);
    hi_wena = wb_hilo && !abort;
    lo_wena = wb_hilo && !abort;
    rf_wena = wb_rf && !abort;
    done    = wb_done && !abort;
    dz_flag = wb_dz && !abort;
  end

  // Sequencer FSM: accept in IDLE/WB, count latency in RUN, one write-back cycle in WB
  always_ff @(posedge clock_in) begin
    if (reset_signal) begin
      state       <= IDLE;
      count       <= '0;
      op_is_mul   <= 1'b0;
      unit_start  <= 1'b0;
      unit_div    <= 1'b0;
      unit_signed <= 1'b0;
      rf_waddr    <= '0;
      wb_hilo     <= 1'b0;
      wb_rf       <= 1'b0;
      wb_done     <= 1'b0;
      wb_dz       <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      unit_start <= 1'b0;
      wb_hilo    <= 1'b0;
      wb_rf      <= 1'b0;
      wb_done    <= 1'b0;
      wb_dz      <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        IDLE, WB: begin
          state <= IDLE;
          if (accept) begin
            if (op_legal) begin
              // Unit controls and destination stay latched until the next legal op
              unit_div    <= op_div;
              unit_signed <= op_signed;
              rf_waddr    <= op_rd;
              op_is_mul   <= (op_code == 3'd4);
              if (dz_skip) begin
                state   <= WB;
                wb_done <= 1'b1;
                wb_dz   <= 1'b1;
              end else begin
                state      <= RUN;
                count      <= op_div ? DIV_LOAD : MULT_LOAD;
                unit_start <= 1'b1;
              end
            end else begin
              illegal_op <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (count == '0) begin
            state   <= WB;
            wb_done <= 1'b1;
            wb_hilo <= !op_is_mul;
            wb_rf   <= op_is_mul;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_multicycle_sequencer.md
Name: muldiv_multicycle_sequencer

Overview:
- Parametrised sequencer for long-latency multiply/divide operations in the multicycle CPU54 core.
- The main controller hands over one op via a valid/ready handshake. This block pulses the arithmetic unit start, counts the configured latency, then issues one write-back cycle (HI/LO or GPR) and a done pulse.
- Generalises the fixed 17/33-cycle wait loop with per-class latencies, back-to-back issue, abort, divide-by-zero short-cut and illegal-op reporting.

Parameters:
MULT_CYCLES, 17, RUN-phase cycles for MULT/MULTU/MUL (>=1)
DIV_CYCLES, 33, RUN-phase cycles for DIV/DIVU (>=1)
DIV_ZERO_SKIP, 1, 1 = a divide with zero divisor skips RUN and writes nothing; 0 = runs normally
REG_ADDR_W, 5, GPR address width

Ports:
clock_in  input  1  clock; all state changes on its rising edge
reset_signal  input  1  synchronous, active-high reset
op_valid  input  1  controller presents an op
op_ready  output  1  sequencer can accept (combinational)
op_code  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MUL(to GPR), 5-7 illegal
op_rd  input  REG_ADDR_W  destination GPR for MUL
divisor_zero  input  1  divisor==0, sampled at accept
abort  input  1  exception/flush from controller
unit_start  output  1  one-cycle start pulse to mul/div unit
unit_div  output  1  1 = divider selected (held for whole op)
unit_signed  output  1  signed op (held)
busy  output  1  state != IDLE
hi_wena  output  1  HI write enable
lo_wena  output  1  LO write enable
rf_wena  output  1  GPR write enable (MUL)
rf_waddr  output  REG_ADDR_W  GPR write address (held)
done  output  1  one-cycle completion pulse
dz_flag  output  1  qualifies done: op ended by divide-by-zero skip
illegal_op  output  1  one-cycle pulse: op_code 5-7 was accepted

Behaviour:
- Accept = op_valid & op_ready at a rising edge. op_ready = (state==IDLE | state==WB) & ~abort & ~reset_signal.
- States: IDLE, RUN, WB. Down-counter width = clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- Reset (synchronous, wins over everything): state IDLE. All registered outputs 0: unit_start, unit_div, unit_signed, hi/lo/rf_wena, rf_waddr, done, dz_flag, illegal_op. Counter cleared.
- Accept of legal op 0-4:
  - Latch op class, signedness, op_rd.
  - Load counter with MULT_CYCLES-1 or DIV_CYCLES-1.
  - Enter RUN. unit_start is high in the first RUN cycle only.
- Timing: accept at edge 0 -> RUN during cycles 1..LAT -> WB in cycle LAT+1.
- RUN: counter decrements each cycle. At count 0 the next state is WB.
- WB:
  - Exactly one cycle, done=1.
  - MULT/MULTU/DIV/DIVU: hi_wena=lo_wena=1.
  - MUL: rf_wena=1 with rf_waddr=latched op_rd.
  - op_ready is high in WB, so a new accept in WB goes straight to RUN (no IDLE bubble). Otherwise the next state is IDLE.
- Divide by zero: DIV/DIVU accepted with divisor_zero=1 and DIV_ZERO_SKIP=1 goes directly to WB next cycle. In that WB cycle done=1, dz_flag=1, no write enables, no unit_start.
- Illegal op_code 5-7: accepted (op_ready handshake completes), illegal_op pulses the next cycle, state unchanged (IDLE, or WB->IDLE).
- Abort:
  - In RUN: next state IDLE, no WB, no done.
  - In WB: suppresses all write enables and done that cycle.
  - Abort blocks acceptance (op_ready=0).
  - An op in WB is suppressed even if a new op was offered.
- Reset mid-RUN: returns to IDLE with no write-back.
- busy is high in RUN and WB.
- unit_div, unit_signed and rf_waddr hold their values until the next accept.

Test Plan:
- Reset, then MULT (op_code 0) accepted at edge 0 -> unit_start in cycle 1, busy cycles 1..18, hi_wena=lo_wena=done=1 in cycle 18 only, op_ready back high in cycle 18.
- DIVU (3) with divisor_zero=0 -> WB in cycle 34. Then DIV (2) with divisor_zero=1 -> WB in cycle 1, dz_flag=1, no enables, no unit_start. Repeat with DIV_ZERO_SKIP=0 -> WB in cycle 34.
- MUL (4), op_rd=9, op_valid held for a second MULTU -> cycle 18 rf_wena=1, rf_waddr=9, second op accepted in the same cycle, its unit_start in cycle 19, its WB in cycle 36.
- DIV accepted, abort pulsed in cycle 10 -> IDLE in cycle 11, no done/enables. Abort in the WB cycle of a MULT -> no enables, no done. Abort together with op_valid in IDLE -> op not accepted.
- op_code 6 offered -> accepted, illegal_op pulses once, busy stays 0.
- Override MULT_CYCLES=1, DIV_CYCLES=4 -> MULT WB in cycle 2, DIV WB in cycle 5. reset_signal asserted mid-RUN -> all outputs 0 the next cycle, op_ready=1 after release.
